// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mul_div_unit_pkg
//  Brief   : Op encodings, FSM state codes and op-class decode helpers for
//            the iterative multiply/divide unit. The controller's
//            alucontrol decode maps onto the same op codes.
//  Rev     : 1.0  initial release
// ============================================================================
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MADD  = 3'b100,
        MDU_MADDU = 3'b101,
        MDU_MSUB  = 3'b110,
        MDU_MSUBU = 3'b111
    } mduOp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mduState_e;

    // Divide class: DIV / DIVU
    function automatic logic isDiv(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Even op codes are the signed flavours
    function automatic logic isSigned(input logic [2:0] op);
        return !op[0];
    endfunction

    // Accumulating ops (MADD/MADDU/MSUB/MSUBU)
    function automatic logic isAcc(input logic [2:0] op);
        return op[2];
    endfunction

    // Subtracting accumulate (MSUB/MSUBU)
    function automatic logic isSub(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ============================================================================
//  Module  : mdu_div_step
//  Brief   : One combinational restoring-division step. Shifts the next
//            dividend bit into the partial remainder, subtracts the divisor
//            if it fits and shifts the resulting quotient bit in.
//  Rev     : 1.0  initial release
// ============================================================================
module mdu_div_step
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    // Partial remainder needs one extra bit after the shift
    logic [WIDTH:0] w_shRem;
    logic [WIDTH:0] w_diff;
    logic           w_fits;

    assign w_shRem = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shRem - {1'b0, i_divisor};
    // No borrow out of the top bit means the divisor fits
    assign w_fits  = !w_diff[WIDTH];
    assign o_rem   = w_fits ? w_diff[WIDTH-1:0] : w_shRem[WIDTH-1:0];
    assign o_quo   = {i_quo[WIDTH-2:0], w_fits};

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module  : mul_div_unit
//  Brief   : Iterative signed/unsigned multiply, divide and multiply-
//            accumulate for the E stage. Works on operand magnitudes and
//            fixes the sign at the end; drives the E-stage stall and
//            returns a registered {HI,LO} pair with a one-cycle valid.
//  Rev     : 1.0  initial release
// ============================================================================
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [2*WIDTH-1:0] hilo_in,
    input  logic               cancel,
    output logic               stall_o,
    output logic               valid_o,
    output logic [WIDTH-1:0]   result_hi,
    output logic [WIDTH-1:0]   result_lo,
    output logic               div_by_zero
);

    localparam int                  c_cntWidth = $clog2(WIDTH);
    localparam logic [c_cntWidth-1:0] c_lastDiv = c_cntWidth'(WIDTH - 1);
    localparam logic [c_cntWidth-1:0] c_lastMul = c_cntWidth'(WIDTH / MUL_BITS - 1);

    mduState_e             r_state;
    mduState_e             w_nextState;
    logic [2:0]            r_op;
    logic [WIDTH-1:0]      r_absB;      // divisor, or multiplier shifted right
    logic [2*WIDTH-1:0]    r_mcand;     // multiplicand shifted left
    logic [2*WIDTH-1:0]    r_acc;       // product, or {rem,quo} for divide
    logic [2*WIDTH-1:0]    r_hilo;
    logic                  r_negRes;
    logic                  r_negRem;
    logic                  r_dbz;
    logic [c_cntWidth-1:0] r_count;

    logic                  w_accept;
    logic                  w_startDbz;
    logic                  w_signedIn;
    logic                  w_last;
    logic [WIDTH-1:0]      w_absA;
    logic [WIDTH-1:0]      w_absB;
    logic [2*WIDTH-1:0]    w_accNext;
    logic [2*WIDTH-1:0]    w_prod;
    logic [2*WIDTH-1:0]    w_mulRes;
    logic [WIDTH-1:0]      w_remNext;
    logic [WIDTH-1:0]      w_quoNext;
    logic [WIDTH-1:0]      w_remFix;
    logic [WIDTH-1:0]      w_quoFix;

    assign w_accept   = (r_state == IDLE) && start && !cancel;
    assign w_startDbz = isDiv(op) && (src_b == '0);
    assign w_signedIn = isSigned(op);
    assign w_absA     = (w_signedIn && src_a[WIDTH-1]) ? -src_a : src_a;
    assign w_absB     = (w_signedIn && src_b[WIDTH-1]) ? -src_b : src_b;
    assign w_last     = (r_count == (isDiv(r_op) ? c_lastDiv : c_lastMul));

    // Shift-add: retire MUL_BITS multiplier bits into the accumulator
    always_comb begin
        w_accNext = r_acc;
        for (int k = 0; k < MUL_BITS; k++) begin
            if (r_absB[k]) begin
                w_accNext = w_accNext + (r_mcand << k);
            end
        end
    end

    mdu_div_step #(
        .WIDTH(WIDTH)
    ) u_divStep (
        .i_rem    (r_acc[2*WIDTH-1:WIDTH]),
        .i_quo    (r_acc[WIDTH-1:0]),
        .i_divisor(r_absB),
        .o_rem    (w_remNext),
        .o_quo    (w_quoNext)
    );

    // Sign fix and accumulate, applied only on the final iteration
    assign w_prod   = r_negRes ? -w_accNext : w_accNext;
    assign w_mulRes = !isAcc(r_op) ? w_prod :
                      (isSub(r_op) ? (r_hilo - w_prod) : (r_hilo + w_prod));
    assign w_quoFix = r_negRes ? -w_quoNext : w_quoNext;
    assign w_remFix = r_negRem ? -w_remNext : w_remNext;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state plus stall/valid; cancel overrides everything
    always_comb begin
        w_nextState = r_state;
        stall_o     = 1'b0;
        valid_o     = 1'b0;
        if (cancel) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        stall_o     = 1'b1;
                        w_nextState = w_startDbz ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    stall_o = 1'b1;
                    if (w_last) begin
                        w_nextState = DONE;
                    end
                end
                DONE: begin
                    valid_o     = 1'b1;
                    w_nextState = IDLE;
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    assign div_by_zero = valid_o && r_dbz;

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_absB    <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_hilo    <= '0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_dbz     <= 1'b0;
            r_count   <= '0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            if (w_accept) begin
                r_op     <= op;
                r_absB   <= w_absB;
                r_mcand  <= {{WIDTH{1'b0}}, w_absA};
                r_acc    <= isDiv(op) ? {{WIDTH{1'b0}}, w_absA} : '0;
                r_hilo   <= hilo_in;
                r_negRes <= w_signedIn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                r_negRem <= w_signedIn && src_a[WIDTH-1];
                r_dbz    <= w_startDbz;
                r_count  <= '0;
                if (w_startDbz) begin
                    result_hi <= src_a;
                    result_lo <= '1;
                end
            end else if ((r_state == BUSY) && !cancel) begin
                r_count <= r_count + 1'b1;
                if (isDiv(r_op)) begin
                    r_acc <= {w_remNext, w_quoNext};
                    if (w_last) begin
                        result_hi <= w_remFix;
                        result_lo <= w_quoFix;
                    end
                end else begin
                    r_acc   <= w_accNext;
                    r_mcand <= r_mcand << MUL_BITS;
                    r_absB  <= r_absB >> MUL_BITS;
                    if (w_last) begin
                        result_hi <= w_mulRes[2*WIDTH-1:WIDTH];
                        result_lo <= w_mulRes[WIDTH-1:0];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
